// File: rtl/mem_arb_pkg.sv
// Purpose: shared types and constants for the two-port lower-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a. Exports state encoding, port ids, bus widths and the memory request bundle.
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] READ  = 2'b01;
  localparam logic [1:0] WRITE = 2'b10;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int ADDR_W = 13;
  localparam int LINE_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_READ  = READ,
    ST_WRITE = WRITE
  } state_t;

  // Everything the arbiter drives toward memory, held in one register.
  typedef struct packed {
    logic              rreq;
    logic [ADDR_W-1:0] raddr;
    logic              wreq;
    logic [ADDR_W-1:0] waddr;
    logic [BYTE_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Purpose: two-requester round-robin pick; on contention the requester that was not served last wins.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
// Ports: pend[1:0] pending requesters, last = most recently served id,
//        winner = selected id (0 when nothing pending), any = at least one pending.
module rr_pick2 (
  input  logic [1:0] pend,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  always_comb begin
    any = |pend;
    if (&pend) begin
      winner = ~last;
    end else begin
      winner = pend[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one lower memory between the instruction cache (port 0) and data cache (port 1).
// Latency: grant sampled in cycle N drives memory in N+1; completion is passed back in the response cycle.
// Backpressure: one transaction in flight; other requests wait (level held) until granted; hung transactions abort after TIMEOUT cycles.
// Ports: clk/reset (sync, active-high); per port N: rreq/raddr, wreq/waddr/wdata in,
//        rdata_to/rvalid_to/wack_to out; memory side: registered rreq/raddr/wreq/waddr/wdata out,
//        rdata/rvalid/wack in; err_timeout sticky flag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              rreq_p0,
  input  logic [ADDR_W-1:0] raddr_p0,
  input  logic              wreq_p0,
  input  logic [ADDR_W-1:0] waddr_p0,
  input  logic [BYTE_W-1:0] wdata_p0,
  output logic [LINE_W-1:0] rdata_to_p0,
  output logic              rvalid_to_p0,
  output logic              wack_to_p0,

  input  logic              rreq_p1,
  input  logic [ADDR_W-1:0] raddr_p1,
  input  logic              wreq_p1,
  input  logic [ADDR_W-1:0] waddr_p1,
  input  logic [BYTE_W-1:0] wdata_p1,
  output logic [LINE_W-1:0] rdata_to_p1,
  output logic              rvalid_to_p1,
  output logic              wack_to_p1,

  output logic              rreq_to_mem,
  output logic [ADDR_W-1:0] raddr_to_mem,
  output logic              wreq_to_mem,
  output logic [ADDR_W-1:0] waddr_to_mem,
  output logic [BYTE_W-1:0] wdata_to_mem,
  input  logic [LINE_W-1:0] rdata_from_mem,
  input  logic              rvalid_from_mem,
  input  logic              wack_from_mem,

  output logic              err_timeout
);

  // Counter value on which a transaction with no response is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t   state_q;
  logic     grant_q;
  logic     last_grant_q;
  logic [7:0] tmo_cnt_q;
  logic [7:0] tmo_cnt_d;
  logic     err_timeout_q;
  mem_req_t mem_q;

  logic              winner;
  logic              any_pend;
  logic              win_wreq;
  logic [ADDR_W-1:0] win_raddr;
  logic [ADDR_W-1:0] win_waddr;
  logic [BYTE_W-1:0] win_wdata;
  logic              rd_cpl;
  logic              wr_cpl;

  rr_pick2 u_pick (
    .pend   ({wreq_p1 | rreq_p1, wreq_p0 | rreq_p0}),
    .last   (last_grant_q),
    .winner (winner),
    .any    (any_pend)
  );

  // Winner's request fields; only ever feed registers, never memory outputs directly.
  assign win_wreq  = (winner == PORT1) ? wreq_p1  : wreq_p0;
  assign win_raddr = (winner == PORT1) ? raddr_p1 : raddr_p0;
  assign win_waddr = (winner == PORT1) ? waddr_p1 : waddr_p0;
  assign win_wdata = (winner == PORT1) ? wdata_p1 : wdata_p0;

  // A response only counts when it matches the transaction type in flight.
  assign rd_cpl = (state_q == ST_READ)  && rvalid_from_mem;
  assign wr_cpl = (state_q == ST_WRITE) && wack_from_mem;

  assign tmo_cnt_d = tmo_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= PORT0;
      last_grant_q  <= PORT1;  // port 0 wins the first contention
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
      mem_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_pend) begin
            grant_q   <= winner;
            tmo_cnt_q <= '0;
            // Write first so write-through data lands before a refill of the same line.
            if (win_wreq) begin
              state_q     <= ST_WRITE;
              mem_q.wreq  <= 1'b1;
              mem_q.waddr <= win_waddr;
              mem_q.wdata <= win_wdata;
            end else begin
              state_q     <= ST_READ;
              mem_q.rreq  <= 1'b1;
              mem_q.raddr <= win_raddr;
            end
          end
        end
        ST_READ, ST_WRITE: begin
          if (rd_cpl || wr_cpl) begin
            mem_q        <= '0;
            last_grant_q <= grant_q;
            state_q      <= ST_IDLE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Abandon the hung transaction; the requester is re-arbitrated if still asking.
            mem_q         <= '0;
            err_timeout_q <= 1'b1;
            last_grant_q  <= grant_q;
            state_q       <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
          end
        end
        default: begin
          mem_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rreq_to_mem  = mem_q.rreq;
  assign raddr_to_mem = mem_q.raddr;
  assign wreq_to_mem  = mem_q.wreq;
  assign waddr_to_mem = mem_q.waddr;
  assign wdata_to_mem = mem_q.wdata;
  assign err_timeout  = err_timeout_q;

  // Completions are steered to the granted port in the response cycle.
  assign rvalid_to_p0 = rd_cpl && (grant_q == PORT0);
  assign rvalid_to_p1 = rd_cpl && (grant_q == PORT1);
  assign wack_to_p0   = wr_cpl && (grant_q == PORT0);
  assign wack_to_p1   = wr_cpl && (grant_q == PORT1);
  assign rdata_to_p0  = rvalid_to_p0 ? rdata_from_mem : '0;
  assign rdata_to_p1  = rvalid_to_p1 ? rdata_from_mem : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed, table-driven check of mem_port_arbiter with hand-written timeout and reset sequences.
// Latency: one vector per clock cycle; outputs sampled mid-cycle.
// Backpressure: n/a.
module tb_mem_port_arbiter;

  localparam logic [12:0] RA0 = 13'h0A4;
  localparam logic [12:0] RA1 = 13'h010;
  localparam logic [12:0] WA0 = 13'h0C3;
  localparam logic [7:0]  WD0 = 8'h3C;
  localparam logic [12:0] WA1 = 13'h010;
  localparam logic [7:0]  WD1 = 8'h5A;

  typedef struct packed {
    logic        rq;
    logic [12:0] ra;
    logic        wq;
    logic [12:0] wa;
    logic [7:0]  wd;
    logic [3:0]  cpl;  // {wack_to_p1, rvalid_to_p1, wack_to_p0, rvalid_to_p0}
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        err;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;  // {wreq_p1, rreq_p1, wreq_p0, rreq_p0}
    logic        mrv;
    logic        mwa;
    logic [31:0] mrd;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rreq_p0, wreq_p0, rreq_p1, wreq_p1;
  logic [12:0] raddr_p0, waddr_p0, raddr_p1, waddr_p1;
  logic [7:0]  wdata_p0, wdata_p1;
  logic [31:0] rdata_to_p0, rdata_to_p1;
  logic        rvalid_to_p0, rvalid_to_p1, wack_to_p0, wack_to_p1;
  logic        rreq_to_mem, wreq_to_mem;
  logic [12:0] raddr_to_mem, waddr_to_mem;
  logic [7:0]  wdata_to_mem;
  logic [31:0] rdata_from_mem;
  logic        rvalid_from_mem, wack_from_mem;
  logic        err_timeout;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .rreq_p0         (rreq_p0),
    .raddr_p0        (raddr_p0),
    .wreq_p0         (wreq_p0),
    .waddr_p0        (waddr_p0),
    .wdata_p0        (wdata_p0),
    .rdata_to_p0     (rdata_to_p0),
    .rvalid_to_p0    (rvalid_to_p0),
    .wack_to_p0      (wack_to_p0),
    .rreq_p1         (rreq_p1),
    .raddr_p1        (raddr_p1),
    .wreq_p1         (wreq_p1),
    .waddr_p1        (waddr_p1),
    .wdata_p1        (wdata_p1),
    .rdata_to_p1     (rdata_to_p1),
    .rvalid_to_p1    (rvalid_to_p1),
    .wack_to_p1      (wack_to_p1),
    .rreq_to_mem     (rreq_to_mem),
    .raddr_to_mem    (raddr_to_mem),
    .wreq_to_mem     (wreq_to_mem),
    .waddr_to_mem    (waddr_to_mem),
    .wdata_to_mem    (wdata_to_mem),
    .rdata_from_mem  (rdata_from_mem),
    .rvalid_from_mem (rvalid_from_mem),
    .wack_from_mem   (wack_from_mem),
    .err_timeout     (err_timeout)
  );

  function automatic out_t oz(input logic err);
    out_t o = '0;
    o.err = err;
    return o;
  endfunction

  function automatic out_t ord(input logic [12:0] a, input logic [3:0] cpl,
                               input logic [31:0] rd0, input logic [31:0] rd1, input logic err);
    out_t o = '0;
    o.rq = 1'b1; o.ra = a; o.cpl = cpl; o.rd0 = rd0; o.rd1 = rd1; o.err = err;
    return o;
  endfunction

  function automatic out_t owr(input logic [12:0] a, input logic [7:0] d,
                               input logic [3:0] cpl, input logic err);
    out_t o = '0;
    o.wq = 1'b1; o.wa = a; o.wd = d; o.cpl = cpl; o.err = err;
    return o;
  endfunction

  task automatic add(input logic rst, input logic [3:0] req, input logic mrv,
                     input logic mwa, input logic [31:0] mrd, input out_t exp);
    vec_t v;
    v.rst = rst; v.req = req; v.mrv = mrv; v.mwa = mwa; v.mrd = mrd; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance past the next edge.
  task automatic step(input logic rst, input logic [3:0] req, input logic mrv,
                      input logic mwa, input logic [31:0] mrd, input out_t exp, input string name);
    out_t act;
    reset = rst;
    rreq_p0 = req[0]; wreq_p0 = req[1]; rreq_p1 = req[2]; wreq_p1 = req[3];
    rvalid_from_mem = mrv; wack_from_mem = mwa; rdata_from_mem = mrd;
    #2;
    act.rq = rreq_to_mem;  act.ra = raddr_to_mem;
    act.wq = wreq_to_mem;  act.wa = waddr_to_mem; act.wd = wdata_to_mem;
    act.cpl = {wack_to_p1, rvalid_to_p1, wack_to_p0, rvalid_to_p0};
    act.rd0 = rdata_to_p0; act.rd1 = rdata_to_p1; act.err = err_timeout;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rreq_p0 = 0; wreq_p0 = 0; rreq_p1 = 0; wreq_p1 = 0;
    raddr_p0 = RA0; waddr_p0 = WA0; wdata_p0 = WD0;
    raddr_p1 = RA1; waddr_p1 = WA1; wdata_p1 = WD1;
    rdata_from_mem = '0; rvalid_from_mem = 0; wack_from_mem = 0;

    // Reset state, then single read from port 0 with response in cycle 4.
    add(0, 4'b0000, 0, 0, 32'h0, oz(0));
    add(0, 4'b0001, 0, 0, 32'h0, oz(0));
    add(0, 4'b0001, 0, 0, 32'h0, ord(RA0, 4'b0000, 0, 0, 0));
    add(0, 4'b0001, 0, 0, 32'h0, ord(RA0, 4'b0000, 0, 0, 0));
    add(0, 4'b0001, 0, 0, 32'h0, ord(RA0, 4'b0000, 0, 0, 0));
    add(0, 4'b0001, 1, 0, 32'hDEADBEEF, ord(RA0, 4'b0001, 32'hDEADBEEF, 0, 0));
    add(0, 4'b0000, 0, 0, 32'h0, oz(0));
    // Contention after reset: port 0 first, then port 1 beats a re-requesting port 0.
    add(1, 4'b0000, 0, 0, 32'h0, oz(0));
    add(0, 4'b0101, 0, 0, 32'h0, oz(0));
    add(0, 4'b0101, 0, 0, 32'h0, ord(RA0, 4'b0000, 0, 0, 0));
    add(0, 4'b0101, 1, 0, 32'h11111111, ord(RA0, 4'b0001, 32'h11111111, 0, 0));
    add(0, 4'b0101, 0, 0, 32'h0, oz(0));
    add(0, 4'b0101, 0, 0, 32'h0, ord(RA1, 4'b0000, 0, 0, 0));
    add(0, 4'b0101, 1, 0, 32'h22222222, ord(RA1, 4'b0100, 0, 32'h22222222, 0));
    add(0, 4'b0001, 0, 0, 32'h0, oz(0));
    add(0, 4'b0001, 0, 0, 32'h0, ord(RA0, 4'b0000, 0, 0, 0));
    add(0, 4'b0001, 1, 0, 32'h33333333, ord(RA0, 4'b0001, 32'h33333333, 0, 0));
    add(0, 4'b0000, 0, 0, 32'h0, oz(0));
    // Port 1 write beats its own read; stray rvalid in WRITE, stray wack in READ, both at once.
    add(0, 4'b1100, 0, 0, 32'h0, oz(0));
    add(0, 4'b1100, 0, 0, 32'h0, owr(WA1, WD1, 4'b0000, 0));
    add(0, 4'b1100, 1, 0, 32'h44444444, owr(WA1, WD1, 4'b0000, 0));
    add(0, 4'b1100, 0, 1, 32'h0, owr(WA1, WD1, 4'b1000, 0));
    add(0, 4'b0100, 0, 0, 32'h0, oz(0));
    add(0, 4'b0100, 0, 0, 32'h0, ord(RA1, 4'b0000, 0, 0, 0));
    add(0, 4'b0100, 0, 1, 32'h0, ord(RA1, 4'b0000, 0, 0, 0));
    add(0, 4'b0100, 0, 0, 32'h0, ord(RA1, 4'b0000, 0, 0, 0));
    add(0, 4'b0100, 1, 1, 32'h55555555, ord(RA1, 4'b0100, 0, 32'h55555555, 0));
    add(0, 4'b0000, 1, 0, 32'h66666666, oz(0));
    add(0, 4'b0000, 0, 0, 32'h0, oz(0));
    // Port 0 write then read.
    add(0, 4'b0011, 0, 0, 32'h0, oz(0));
    add(0, 4'b0011, 0, 0, 32'h0, owr(WA0, WD0, 4'b0000, 0));
    add(0, 4'b0011, 0, 1, 32'h0, owr(WA0, WD0, 4'b0010, 0));
    add(0, 4'b0001, 0, 0, 32'h0, oz(0));
    add(0, 4'b0001, 1, 0, 32'h77777777, ord(RA0, 4'b0001, 32'h77777777, 0, 0));
    add(0, 4'b0000, 0, 0, 32'h0, oz(0));

    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].mrv, tbl[i].mwa, tbl[i].mrd, tbl[i].exp,
           $sformatf("tbl[%0d]", i));
    end

    // Timeout: memory silent for 8 cycles in READ, abort, sticky error, re-grant of port 0.
    step(0, 4'b0001, 0, 0, 32'h0, oz(0), "tmo_grant");
    for (int k = 0; k < 8; k++) begin
      step(0, 4'b0001, 0, 0, 32'h0, ord(RA0, 4'b0000, 0, 0, 0), $sformatf("tmo_wait%0d", k));
    end
    step(0, 4'b0001, 0, 0, 32'h0, oz(1), "tmo_abort");
    step(0, 4'b0001, 0, 0, 32'h0, ord(RA0, 4'b0000, 0, 0, 1), "tmo_regrant");
    step(0, 4'b0001, 1, 0, 32'h88888888, ord(RA0, 4'b0001, 32'h88888888, 0, 1), "tmo_cpl");
    step(0, 4'b0000, 0, 0, 32'h0, oz(1), "tmo_sticky");

    // Reset during a port 1 read: memory side clears, later stray rvalid is ignored.
    step(0, 4'b0100, 0, 0, 32'h0, oz(1), "rst_grant");
    step(0, 4'b0100, 0, 0, 32'h0, ord(RA1, 4'b0000, 0, 0, 1), "rst_inread");
    step(1, 4'b0000, 0, 0, 32'h0, ord(RA1, 4'b0000, 0, 0, 1), "rst_cycle");
    step(0, 4'b0000, 0, 0, 32'h0, oz(0), "rst_cleared");
    step(0, 4'b0000, 1, 0, 32'h99999999, oz(0), "rst_stray_rvalid");
    step(0, 4'b0000, 0, 0, 32'h0, oz(0), "rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single lower memory module between two cache requesters, port 0 (instruction cache) and port 1 (data cache).
- Each port presents the cache's lower-memory interface: read refill (13-bit address, 32-bit line returned) and write-through (13-bit address, 8-bit byte).
- Grants one transaction at a time, using round-robin between ports and write-before-read within a port.
- Steers the memory response back to the granted port and flags memory transactions that hang.

Parameters:
- TIMEOUT, 255, cycles a granted transaction may wait for rvalid/wack before it is aborted (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rreq_pN  in  1  port N read request, level, held until rvalid_to_pN (N = 0, 1; same for every per-port signal below)
- raddr_pN  in  13  port N read-line base address
- wreq_pN  in  1  port N write request, level, held until wack_to_pN
- waddr_pN  in  13  port N write address
- wdata_pN  in  8  port N write byte
- rdata_to_pN  out  32  read line returned to port N
- rvalid_to_pN  out  1  read complete for port N
- wack_to_pN  out  1  write complete for port N
- rreq_to_mem  out  1  memory read request
- raddr_to_mem  out  13  memory read address
- wreq_to_mem  out  1  memory write request
- waddr_to_mem  out  13  memory write address
- wdata_to_mem  out  8  memory write byte
- rdata_from_mem  in  32  memory read line
- rvalid_from_mem  in  1  memory read data valid (1-cycle pulse)
- wack_from_mem  in  1  memory write done (1-cycle pulse)
- err_timeout  out  1  sticky timeout flag

Behaviour:
- States: IDLE, READ, WRITE. Registers: grant (1 b), last_grant (1 b), tmo_cnt (8 b), err_timeout.
- Reset (synchronous): state=IDLE, last_grant=1 (port 0 has first priority), tmo_cnt=0, all registered outputs 0, err_timeout=0. Reset mid-transaction drops the memory request in the next cycle; the transaction is not resumed.
- IDLE, request selection:
  - A port is pending if its wreq or rreq is high.
  - If both ports are pending, the port != last_grant wins; otherwise the single pending port wins.
  - Within the winning port, a write beats a read, so write-through data lands before a refill of the same line.
- IDLE, grant actions (register update at the sampling edge):
  - grant <= winner.
  - Next state is WRITE (wreq_to_mem=1, waddr/wdata copied from the port) or READ (rreq_to_mem=1, raddr copied from the port).
  - Memory-side outputs are registered: request sampled in cycle N appears at the memory in N+1.
  - Address and data are latched at grant and stay stable for the whole transaction.
- READ completion:
  - In a cycle with rvalid_from_mem=1: rvalid_to_p[grant]=1 and rdata_to_p[grant]=rdata_from_mem, combinationally in the same cycle.
  - At that edge: rreq_to_mem<=0, raddr_to_mem<=0, last_grant<=grant, state<=IDLE.
- WRITE completion: same as READ, using wack_from_mem and wack_to_p[grant]; wreq/waddr/wdata_to_mem are cleared.
- Idle bus values:
  - rdata_to_pN = 0 when that port is not being completed.
  - rvalid_to_pN = 0 and wack_to_pN = 0 outside a matching completion.
- Stray responses:
  - rvalid_from_mem in IDLE or WRITE is ignored.
  - wack_from_mem in IDLE or READ is ignored.
  - If both arrive in the same cycle, only the one matching the state is honoured.
- Back-to-back: the cycle after a completion the state is IDLE. Requesters have dropped their request by then, so there is no double grant. A new grant may be sampled in that cycle.
- Timeout:
  - tmo_cnt clears on entry to READ/WRITE and increments every cycle without a response.
  - When tmo_cnt == TIMEOUT-1 with no response: drop the memory request, set err_timeout=1 (sticky until reset), last_grant<=grant, state<=IDLE.
  - The aborted port gets no completion and is re-arbitrated if it still requests.
- No combinational path from port request inputs to memory outputs.

Decomposition:
- Package mem_arb_pkg holds:
  - state encoding localparams IDLE=2'b00, READ=2'b01, WRITE=2'b10;
  - PORT0=1'b0, PORT1=1'b1;
  - width constants ADDR_W=13, LINE_W=32, BYTE_W=8.
- One sub-module, rr_pick2: combinational two-requester round-robin pick with inputs pend[1:0] and last, and outputs winner and any. Write-before-read selection stays in the top.

Test Plan:
- Single read: port 0 raises rreq_p0 with raddr_p0=13'h0A4 at cycle 0. Expect rreq_to_mem=1 and raddr_to_mem=13'h0A4 at cycle 1. Memory returns rvalid with 32'hDEADBEEF at cycle 4. Expect rvalid_to_p0=1 and rdata_to_p0=32'hDEADBEEF in cycle 4, rreq_to_mem=0 in cycle 5, rvalid_to_p1 never asserted.
- Contention: both ports request reads simultaneously after reset. Expect port 0 granted first and port 1 granted in the cycle after port 0's rvalid. Repeat with both requesting: port 1 is granted first this time.
- Write-before-read: port 1 asserts wreq_p1 (waddr 13'h010, wdata 8'h5A) and rreq_p1 (raddr 13'h010) together. Expect the memory write with 8'h5A first; after wack, the read for 13'h010 is issued.
- Timeout: TIMEOUT=8, port 0 read, memory never responds. Expect rreq_to_mem to drop after 8 cycles in READ, err_timeout=1 and held, then port 0 re-granted.
- Reset mid-read: assert reset for 1 cycle while in READ. Expect all memory outputs 0 the next cycle. A later rvalid_from_mem pulse in IDLE produces no rvalid_to_pN.
- Stray response: wack_from_mem pulse during a READ is ignored. The state stays READ, and wack_to_p0 and wack_to_p1 stay 0.
